// File: rtl/aes_pkg.sv
// Shared AES-128 types, mode encodings and GF(2^8) helpers for the round-transform datapath.
package aes_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = 128;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_FINAL = 2'b01;
  localparam logic [1:0] MODE_ROUND = 2'b10;
  localparam logic [1:0] MODE_MIX   = 2'b11;

  // AES field polynomial x^8+x^4+x^3+x+1 with the x^8 term dropped
  localparam byte_t RED_POLY = 8'h1B;

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_columns_if.sv
// Request/result bus between the AES round FSM and the mix_columns unit.
// The inv signal exists only when AES_INVERSE_EN is defined.
interface mix_columns_if;

  logic            in_valid;
  logic [1:0]      mode;
  aes_pkg::state_t state_in;
  aes_pkg::state_t key_in;
  logic            out_valid;
  aes_pkg::state_t state_out;
`ifdef AES_INVERSE_EN
  logic            inv;

  modport master (output in_valid, mode, state_in, key_in, inv,
                  input  out_valid, state_out);
  modport slave  (input  in_valid, mode, state_in, key_in, inv,
                  output out_valid, state_out);
`else
  modport master (output in_valid, mode, state_in, key_in,
                  input  out_valid, state_out);
  modport slave  (input  in_valid, mode, state_in, key_in,
                  output out_valid, state_out);
`endif

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (a0 in the MSBs).
// With AES_INVERSE_EN defined, inv_i selects InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
`ifdef AES_INVERSE_EN
  input  logic inv_i,
`endif
  input  col_t col_i,
  output col_t col_o
);

  byte_t a0, a1, a2, a3;
  byte_t x0, x1, x2, x3;
  col_t  fwd_c;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3x is expanded as xtime(x)^x
  assign fwd_c = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                  a0 ^ x1 ^ x2 ^ a2 ^ a3,
                  a0 ^ a1 ^ x2 ^ x3 ^ a3,
                  x0 ^ a0 ^ a1 ^ a2 ^ x3};

`ifdef AES_INVERSE_EN
  col_t inv_c;

  assign inv_c = {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                  gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                  gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                  gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};

  assign col_o = inv_i ? inv_c : fwd_c;
`else
  assign col_o = fwd_c;
`endif

endmodule

// File: rtl/mix_columns.sv
// Registered AES round transform: ShiftRows / MixColumns / AddRoundKey selected by mode, 1-cycle latency.
// Optional AES_INVERSE_EN adds bus.inv to select the inverse ShiftRows/MixColumns.
module mix_columns
  import aes_pkg::*;
(
  input logic         clk,
  input logic         reset,
  mix_columns_if.slave bus
);

  state_t sr_fwd_c;
  state_t sr_sel_c;
  state_t mc_in_c;
  state_t mc_out_c;
  state_t result_c;
  state_t state_d, state_q;
  logic   valid_d, valid_q;

`ifdef AES_INVERSE_EN
  state_t sr_inv_c;
`endif

  // Byte n sits at [127-8n -: 8]; row r = n%4, column c = n/4
  for (genvar n = 0; n < 16; n++) begin : g_shift
    localparam int unsigned R   = n % 4;
    localparam int unsigned C   = n / 4;
    localparam int unsigned FWD = 4 * ((C + R) % 4) + R;
    assign sr_fwd_c[127-8*n -: 8] = bus.state_in[127-8*FWD -: 8];
`ifdef AES_INVERSE_EN
    localparam int unsigned INV = 4 * ((C + 4 - R) % 4) + R;
    assign sr_inv_c[127-8*n -: 8] = bus.state_in[127-8*INV -: 8];
`endif
  end

`ifdef AES_INVERSE_EN
  assign sr_sel_c = bus.inv ? sr_inv_c : sr_fwd_c;
`else
  assign sr_sel_c = sr_fwd_c;
`endif

  // MIX-only mode skips ShiftRows
  assign mc_in_c = (bus.mode == MODE_MIX) ? bus.state_in : sr_sel_c;

  for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
    mix_single_column u_col (
`ifdef AES_INVERSE_EN
      .inv_i (bus.inv),
`endif
      .col_i (mc_in_c[127-32*c -: 32]),
      .col_o (mc_out_c[127-32*c -: 32])
    );
  end

  always_comb begin
    result_c = bus.state_in ^ bus.key_in;
    case (bus.mode)
      MODE_ADD:   result_c = bus.state_in ^ bus.key_in;
      MODE_FINAL: result_c = sr_sel_c ^ bus.key_in;
      MODE_ROUND: result_c = mc_out_c ^ bus.key_in;
      MODE_MIX:   result_c = mc_out_c;
      default:    result_c = bus.state_in ^ bus.key_in;
    endcase
  end

  // state_out holds its last value while idle
  always_comb begin
    valid_d = bus.in_valid;
    state_d = state_q;
    if (bus.in_valid) state_d = result_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      state_q <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_mix_columns.sv
// Scoreboard bench for mix_columns: directed vectors push expectations, a negedge monitor pops and compares.
module tb_mix_columns;
  import aes_pkg::*;

  typedef struct {
    string  name;
    state_t exp;
  } exp_t;

  logic   clk;
  logic   reset;
  int     checks;
  int     errors;
  exp_t   exp_q[$];
  exp_t   mon_e;
  state_t last_exp;

  mix_columns_if bus();

  mix_columns dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h", bus.state_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.state_out !== mon_e.exp) begin
          errors++;
          $display("FAIL %s got=%h want=%h", mon_e.name, bus.state_out, mon_e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] m, input state_t s, input state_t k,
                      input state_t e, input string nm);
    exp_t item;
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.state_in = s;
    bus.key_in   = k;
    item.name    = nm;
    item.exp     = e;
    exp_q.push_back(item);
    last_exp     = e;
  endtask

  task automatic check(input string nm, input state_t got, input state_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    last_exp     = '0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.mode     = MODE_ADD;
    bus.state_in = '0;
    bus.key_in   = '0;
`ifdef AES_INVERSE_EN
    bus.inv      = 1'b0;
`endif

    step();
    step();
    check("reset_out_valid", state_t'(bus.out_valid), '0);
    check("reset_state_out", bus.state_out, '0);
    reset = 1'b0;

    // Back-to-back stream of directed vectors
    load(MODE_ADD, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
         128'h193de3bea0f4e22b9ac68d2ae9f84808, "add_fips");
    step();
    load(MODE_ROUND, 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
         128'ha49c7ff2689f352b6b5bea43026a5049, "round_fips");
    step();
    load(MODE_FINAL, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h0,
         128'hd4bf5d30e0b452aeb84111f11e2798e5, "final_fips");
    step();
    load(MODE_MIX, 128'hdb135345db135345db135345db135345, 128'hffffffffffffffffffffffffffffffff,
         128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc, "mix_repeat_key_ignored");
    step();
    load(MODE_MIX, 128'hdb135345f20a225c01010101d4d4d4d5, 128'h123456789abcdef0123456789abcdef0,
         128'h8e4da1bc9fdc589d01010101d5d5d7d6, "mix_mixed_cols");
    step();
    load(MODE_FINAL, 128'h000102030405060708090a0b0c0d0e0f, 128'hffffffffffffffffffffffffffffffff,
         128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4, "final_ramp_key");
    step();
    load(MODE_ADD, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
         128'h000102030405060708090a0b0c0d0e0f, "add_zero_key");
    step();
`ifdef AES_INVERSE_EN
    bus.inv = 1'b1;
    load(MODE_MIX, 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc, 128'h0,
         128'hdb135345db135345db135345db135345, "inv_mix");
    step();
    load(MODE_FINAL, 128'h00050a0f04090e03080d02070c01060b, 128'h0,
         128'h000102030405060708090a0b0c0d0e0f, "inv_final");
    step();
    bus.inv = 1'b0;
`endif

    // Idle: out_valid drops, state_out holds
    bus.in_valid = 1'b0;
    step();
    check("idle_out_valid", state_t'(bus.out_valid), '0);
    check("idle_state_hold", bus.state_out, last_exp);
    step();
    check("idle_state_hold2", bus.state_out, last_exp);

    // Reset wins over in_valid on the same edge
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode     = MODE_ADD;
    bus.state_in = 128'h3243f6a8885a308d313198a2e0370734;
    bus.key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    step();
    check("rst_vs_valid_out_valid", state_t'(bus.out_valid), '0);
    check("rst_vs_valid_state_out", bus.state_out, '0);
    reset = 1'b0;
    load(MODE_ROUND, 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
         128'ha49c7ff2689f352b6b5bea43026a5049, "post_reset_round");
    step();
    bus.in_valid = 1'b0;
    step();
    check("post_reset_idle", state_t'(bus.out_valid), '0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns.md
Name: mix_columns

Overview:
- Registered AES round-transform unit.
- Applies ShiftRows, MixColumns and AddRoundKey to a 128-bit state in one clock.
- Which transforms run is chosen per transaction by a mode field.
- Sits beside the SubBytes and key-expansion logic inside the AES encryption core; the core's round FSM sequences it.

Parameters:
- None. Widths are fixed by AES-128: state and key are 128 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  transaction strobe; inputs are sampled on a clk edge when high.
- mode  input  2  transform select (see Behaviour).
- state_in  input  128  input state.
- key_in  input  128  round key.
- out_valid  output  1  result strobe, high for one cycle per accepted transaction.
- state_out  output  128  registered result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Byte order: byte n = bits [127-8n -: 8], n = 0..15, column-major as in FIPS-197. Row r = n mod 4, column c = n div 4.
- ShiftRows: out[r,c] = in[r,(c+r) mod 4]. Row 0 is unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 bytes.
- MixColumns, per column (a0..a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x) ^ x.
- AddRoundKey: bitwise XOR with key_in.
- mode encoding:
  - 00: ADD only → state_in ^ key_in.
  - 01: final round → ShiftRows(state_in) ^ key_in.
  - 10: full round → MixColumns(ShiftRows(state_in)) ^ key_in.
  - 11: MIX only → MixColumns(state_in); key_in is ignored.
- Latency: exactly 1 cycle. An input accepted at edge k gives out_valid=1 and the matching state_out after edge k.
- Throughput: one transaction per cycle. Back-to-back in_valid gives back-to-back results with no bubbles.
- When in_valid=0: out_valid drops to 0 on the next edge; state_out holds its last value.
- Reset values: out_valid=0, state_out=128'h0.
- Reset wins over in_valid on the same edge; the input is discarded.
- Reset mid-stream: any result in flight is lost. The first edge with reset low and in_valid high behaves normally.
- No backpressure; the consumer must take out_valid when it is asserted.

Optional Feature:
- Macro: AES_INVERSE_EN.
- Defined:
  - Adds input port inv (1 bit).
  - When inv=1, InvShiftRows replaces ShiftRows: out[r,c] = in[r,(c-r) mod 4].
  - When inv=1, InvMixColumns replaces MixColumns: coefficients 0e, 0b, 0d, 09, same rotation pattern.
  - Mode encoding and latency are unchanged.
- Undefined: no inv port; forward transforms only.

Decomposition:
- Shared package aes_pkg holds:
  - mode constants MODE_ADD=2'b00, MODE_FINAL=2'b01, MODE_ROUND=2'b10, MODE_MIX=2'b11;
  - typedefs for a byte and a 128-bit state;
  - the xtime / GF(2^8) multiply functions;
  - the reduction constant 8'h1B.
- One sub-module is natural: mix_single_column, a purely combinational 32-bit column transform, instantiated 4 times.
- ShiftRows and AddRoundKey are wiring/XOR in the top.

Test Plan:
- mode=00, state_in=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c → next cycle state_out=193de3bea0f4e22b9ac68d2ae9f84808, out_valid=1.
- mode=10, state_in=d42711aee0bf98f1b8b45de51e415230, key_in=a0fafe1788542cb123a339392a6c7605 → state_out=a49c7ff2689f352b6b5bea43026a5049.
- mode=01, same state_in, key_in=0 → state_out=d4bf5d30e0b452aeb84111f11e2798e5 (ShiftRows only).
- mode=11, state_in=db135345 repeated in all four columns → state_out=8e4da1bc in each column.
- Back-to-back: vectors 1 and 2 on consecutive cycles → results on consecutive cycles; then in_valid=0 → out_valid=0 and state_out held.
- Reset asserted together with in_valid=1 → out_valid=0, state_out=0 after the edge; the input issued after reset deasserts returns its correct result 1 cycle later.
